// File: rtl/sample_expander_pkg.sv
// Shared DSP helpers: full-scale (clip) codes for an N-bit two's complement converter.
package sample_expander_pkg;

  localparam int CODE_W = 32;

  // Most negative code {1, 0...0}, returned zero-extended to CODE_W bits.
  function automatic logic [CODE_W-1:0] min_code(input int isz);
    return 32'd1 << (isz - 1);
  endfunction

  // Most positive code {0, 1...1}, returned zero-extended to CODE_W bits.
  function automatic logic [CODE_W-1:0] max_code(input int isz);
    return min_code(isz) - 32'd1;
  endfunction

endpackage

// File: rtl/sample_expander_clip_window_counter.sv
// Counts clip codes over windows of 2^WIN_LOG2 valid samples and latches the
// per-window count, threshold alarm and a one-cycle stat_valid strobe.
module sample_expander_clip_window_counter #(
  parameter int WIN_LOG2 = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                i_clip,
  input  logic [WIN_LOG2:0]   i_thresh,
  output logic                o_stat_valid,
  output logic [WIN_LOG2:0]   o_clip_count,
  output logic                o_clip_alarm
);

  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [WIN_LOG2:0]   r_run_cnt;
  logic [WIN_LOG2:0]   r_clip_count;
  logic                r_clip_alarm;
  logic                r_stat_valid;
  logic                w_win_end;
  logic [WIN_LOG2:0]   w_total;

  assign w_win_end = i_valid && (r_win_cnt == '1);
  // At most 2^WIN_LOG2 clips per window, so the extra bit makes overflow impossible.
  assign w_total   = r_run_cnt + (WIN_LOG2+1)'(i_clip);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt    <= '0;
      r_run_cnt    <= '0;
      r_clip_count <= '0;
      r_clip_alarm <= 1'b0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_valid <= w_win_end;
      if (i_valid) begin
        r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
      end
      if (w_win_end) begin
        r_clip_count <= w_total;
        r_clip_alarm <= (w_total >= i_thresh);
        r_run_cnt    <= '0;
      end else if (i_valid && i_clip) begin
        r_run_cnt <= w_total;
      end
    end
  end

  assign o_stat_valid = r_stat_valid;
  assign o_clip_count = r_clip_count;
  assign o_clip_alarm = r_clip_alarm;

endmodule

// File: rtl/sample_expander.sv
// Widens narrow signed ADC samples (sign-extend or MSB-align), flags full-scale
// clip codes and reports windowed clip statistics.
module sample_expander
  import sample_expander_pkg::*;
#(
  parameter int ISZ      = 12,
  parameter int OSZ      = 17,
  parameter int ALIGN    = 0,
  parameter int WIN_LOG2 = 10
) (
  input  logic                clk,
  input  logic                reset,
  // Stream: a sample transfers on every cycle i_in_valid is high; there is no
  // ready, so the consumer must take each o_out_valid beat as it appears.
  input  logic                i_in_valid,
  input  logic [ISZ-1:0]      i_in,
  input  logic [WIN_LOG2:0]   i_clip_thresh,
  input  logic                i_clear_sticky,
  output logic                o_out_valid,
  output logic [OSZ-1:0]      o_out,
  output logic                o_clip,
  output logic                o_clip_sticky,
  output logic                o_stat_valid,
  output logic [WIN_LOG2:0]   o_clip_count,
  output logic                o_clip_alarm
);

  localparam logic [ISZ-1:0] L_MIN_CODE = ISZ'(min_code(ISZ));
  localparam logic [ISZ-1:0] L_MAX_CODE = ISZ'(max_code(ISZ));

  logic [OSZ-1:0] w_wide;
  logic           w_is_clip;
  logic           w_valid_clip;

  logic           r_out_valid;
  logic [OSZ-1:0] r_out;
  logic           r_clip;
  logic           r_clip_sticky;

  generate
    if (ALIGN != 0) begin : g_msb_align
      assign w_wide = {i_in, {(OSZ-ISZ){1'b0}}};
    end else begin : g_sign_ext
      assign w_wide = {{(OSZ-ISZ){i_in[ISZ-1]}}, i_in};
    end
  endgenerate

  assign w_is_clip    = (i_in == L_MIN_CODE) || (i_in == L_MAX_CODE);
  assign w_valid_clip = i_in_valid && w_is_clip;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out         <= '0;
      r_clip        <= 1'b0;
      r_clip_sticky <= 1'b0;
    end else begin
      r_out_valid <= i_in_valid;
      r_clip      <= w_valid_clip;
      if (i_in_valid) begin
        r_out <= w_wide;
      end
      // A new clip beats a simultaneous clear so no event is ever lost.
      if (w_valid_clip) begin
        r_clip_sticky <= 1'b1;
      end else if (i_clear_sticky) begin
        r_clip_sticky <= 1'b0;
      end
    end
  end

  sample_expander_clip_window_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_clip_window_counter (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_in_valid),
    .i_clip       (w_is_clip),
    .i_thresh     (i_clip_thresh),
    .o_stat_valid (o_stat_valid),
    .o_clip_count (o_clip_count),
    .o_clip_alarm (o_clip_alarm)
  );

  assign o_out_valid   = r_out_valid;
  assign o_out         = r_out;
  assign o_clip        = r_clip;
  assign o_clip_sticky = r_clip_sticky;

endmodule

// File: tb/tb_sample_expander.sv
// Directed bench for sample_expander: sign-extend and MSB-align instances,
// clip detection, sticky flag and 16-sample clip statistics windows.
module tb_sample_expander;

  localparam int ISZ = 12;
  localparam int OSZ = 17;
  localparam int WL  = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [ISZ-1:0] in_smp;
  logic [WL:0]   clip_thresh;
  logic          clear_sticky;

  logic          a_out_valid, a_clip, a_sticky, a_stat_valid, a_alarm;
  logic [OSZ-1:0] a_out;
  logic [WL:0]   a_count;
  logic          b_out_valid, b_clip, b_sticky, b_stat_valid, b_alarm;
  logic [OSZ-1:0] b_out;
  logic [WL:0]   b_count;

  int n_checks = 0;
  int n_fails  = 0;
  logic [OSZ-1:0] exp_q[$];

  sample_expander #(.ISZ(ISZ), .OSZ(OSZ), .ALIGN(0), .WIN_LOG2(WL)) u_dut_ext (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_in(in_smp),
    .i_clip_thresh(clip_thresh), .i_clear_sticky(clear_sticky),
    .o_out_valid(a_out_valid), .o_out(a_out), .o_clip(a_clip),
    .o_clip_sticky(a_sticky), .o_stat_valid(a_stat_valid),
    .o_clip_count(a_count), .o_clip_alarm(a_alarm)
  );

  sample_expander #(.ISZ(ISZ), .OSZ(OSZ), .ALIGN(1), .WIN_LOG2(WL)) u_dut_align (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_in(in_smp),
    .i_clip_thresh(clip_thresh), .i_clear_sticky(clear_sticky),
    .o_out_valid(b_out_valid), .o_out(b_out), .o_clip(b_clip),
    .o_clip_sticky(b_sticky), .o_stat_valid(b_stat_valid),
    .o_clip_count(b_count), .o_clip_alarm(b_alarm)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ovld"}, a_out_valid, 0);
    check({tag, "_out"}, a_out, 0);
    check({tag, "_clip"}, a_clip, 0);
    check({tag, "_sticky"}, a_sticky, 0);
    check({tag, "_stat"}, a_stat_valid, 0);
    check({tag, "_count"}, a_count, 0);
    check({tag, "_alarm"}, a_alarm, 0);
    check({tag, "_b_out"}, b_out, 0);
  endtask

  // 16 valid samples, each followed by 'gap' idle cycles; clips where mask bit set.
  task automatic run_window(input logic [15:0] mask, input int gap,
                            input logic [WL:0] exp_cnt, input logic exp_alarm);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      if (mask[i]) in_smp = (i % 2 == 1) ? 12'h7FF : 12'h800;
      else         in_smp = 12'(i * 5 + 1);
      step();
      check("win_ovld", a_out_valid, 1);
      check("win_clip", a_clip, {31'd0, mask[i]});
      check("win_stat", a_stat_valid, (i == 15) ? 1 : 0);
      check("win_stat_b", b_stat_valid, (i == 15) ? 1 : 0);
      if (i == 15) begin
        check("win_count", a_count, exp_cnt);
        check("win_alarm", a_alarm, exp_alarm);
      end
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        step();
        check("gap_ovld", a_out_valid, 0);
        check("gap_stat", a_stat_valid, 0);
      end
    end
    if (gap == 0) step();
    check("post_stat", a_stat_valid, 0);
    check("hold_count", a_count, exp_cnt);
    check("hold_alarm", a_alarm, exp_alarm);
  endtask

  logic [ISZ-1:0] vin   [5] = '{12'h800, 12'h7FF, 12'h123, 12'hFFF, 12'h001};
  logic [OSZ-1:0] vexp_a[5] = '{17'h1F800, 17'h007FF, 17'h00123, 17'h1FFFF, 17'h00001};
  logic [OSZ-1:0] vexp_b[5] = '{17'h10000, 17'h0FFE0, 17'h02460, 17'h1FFE0, 17'h00020};
  logic           vclip [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_smp = '0; clip_thresh = 5'd3; clear_sticky = 1'b0;
    do_reset();
    check_all_zero("rst");

    // Widening, both modes, one cycle latency
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_smp = vin[i];
      exp_q.push_back(vexp_a[i]);
      step();
      check("ext_out", a_out, exp_q.pop_front());
      check("align_out", b_out, vexp_b[i]);
      check("ext_ovld", a_out_valid, 1);
      check("ext_clip", a_clip, {31'd0, vclip[i]});
      check("align_clip", b_clip, {31'd0, vclip[i]});
    end
    check("sticky_set", a_sticky, 1);
    in_valid = 1'b0; in_smp = 12'h555;
    step();
    check("idle_ovld", a_out_valid, 0);
    check("idle_clip", a_clip, 0);
    check("idle_hold", a_out, 17'h00001);
    check("idle_hold_b", b_out, 17'h00020);

    do_reset();
    check_all_zero("rst2");

    // Window with clips at samples 2, 9, 15 then a clean window
    clip_thresh = 5'd3;
    run_window(16'h8204, 0, 5'd3, 1'b1);
    run_window(16'h0000, 0, 5'd0, 1'b0);
    // 1-on/3-off gaps, threshold 0 forces the alarm
    clip_thresh = 5'd0;
    run_window(16'h0020, 3, 5'd1, 1'b1);

    // Sticky: clear alone, then set+clear, then clear alone
    clear_sticky = 1'b1; in_valid = 1'b0;
    step();
    check("sticky_clr", a_sticky, 0);
    in_valid = 1'b1; in_smp = 12'h800;
    step();
    check("sticky_set_wins", a_sticky, 1);
    in_valid = 1'b0;
    check("sticky_same_clip", a_clip, 1);
    step();
    check("sticky_clr2", a_sticky, 0);
    clear_sticky = 1'b0;

    // Reset after 7 samples of a window (window counter already at 1)
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_smp = (i == 6) ? 12'h7FF : 12'(i + 2);
      step();
    end
    check("pre_rst_clip", a_clip, 1);
    check("pre_rst_count", a_count, 5'd1);
    reset = 1'b1; in_valid = 1'b0;
    step();
    reset = 1'b0;
    check_all_zero("midrst");
    clip_thresh = 5'd3;
    run_window(16'h0000, 0, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
